vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the raster scan counters hc/vc and the HSYNC/VSYNC/blank strobes that drive the VGA serial display pipeline. It is the producer of the hc/vc buses that every window/visible-area decoder downstream consumes. It advances one pixel per pixel-enable and emits frame and line markers for the framebuffer fetch logic. Defaults are 1024x768@60 (65 MHz pixel rate).

Parameters:
H_VISIBLE, 1024, active pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum = 1344
V_VISIBLE, 768, active lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
pix_en  input  1  pixel-advance enable; tie high when clk is the pixel clock
hc  output  11  horizontal counter, 0..H_TOTAL-1
vc  output  11  vertical counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per H_POL
vsync  output  1  vertical sync, polarity per V_POL
blank  output  1  high when (hc,vc) is outside the visible area
line_start  output  1  one-cycle pulse when hc becomes 0
frame_start  output  1  one-cycle pulse when hc and vc both become 0

Behaviour:
- Reset: sampled on posedge clk with rst==0; the reset branch has priority over pix_en. hc=0, vc=0, hsync=~H_POL, vsync=~V_POL, blank=0, line_start=0, frame_start=0.
- After release, the first pix_en cycle moves hc to 1. No start pulse is emitted for the reset state.
- Counting, on each posedge with pix_en=1:
  - hc==H_TOTAL-1: hc<=0. Also vc<=(vc==V_TOTAL-1) ? 0 : vc+1.
  - otherwise: hc<=hc+1, vc unchanged.
- pix_en=0: every output holds its value. line_start and frame_start are forced to 0, so each pulse lasts exactly one clk.
- All outputs are registers. hsync, vsync and blank are decoded from the next-state counters, so they align with the hc/vc values on the same cycle (zero relative latency).
- hsync active iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (1048..1183 by default).
- vsync active iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (771..776). vsync transitions coincide with hc wrapping to 0.
- blank = (hc >= H_VISIBLE) | (vc >= V_VISIBLE).
- line_start=1 in the cycle where the registered hc becomes 0. frame_start additionally requires vc becoming 0. Both fire together at frame wrap.
- Width rules:
  - Counters are 11 bits; compares are unsigned.
  - Elaboration error if H_TOTAL or V_TOTAL > 2048, or if any porch or sync parameter is 0.
- Out-of-range guard: if hc >= H_TOTAL or vc >= V_TOTAL (e.g. SEU), the next enabled cycle forces that counter to 0. Wrap logic then resumes normally.
- Reset mid-frame: counters return to 0 on the next clk edge and no start pulse is emitted.

Decomposition:
- Package vga_timing_pkg:
  - default timing constants H_*/V_* for 1024x768@60 and 640x480@60;
  - a typedef for the 11-bit counter (coord_t);
  - a function computing sync windows from parameters.
- Sub-module vga_axis_counter: wrapping counter with enable, terminal-count output and sync-window decode. Instantiated once for the horizontal axis (enable = pix_en) and once for the vertical axis (enable = pix_en & h terminal count).

Test Plan:
- Reset release, pix_en=1, run 1344 cycles -> hc goes 0..1343 then 0. vc goes 0->1 on the wrap. line_start pulses once. hsync low exactly for hc 1048..1183 (136 cycles).
- Full frame, 1344*806=1,083,264 enabled cycles -> exactly one frame_start, coincident with hc=0 and vc=0. vsync low for vc 771..776 (6*1344 cycles). blank high for 1344*806-1024*768 cycles.
- pix_en toggled 1/0 alternately -> counters advance every other clk. Start pulses remain 1 clk wide. Totals are unchanged when counted in enabled cycles.
- rst=0 asserted at hc=500, vc=400 -> next edge gives hc=0, vc=0, hsync=1, vsync=1, blank=0, no frame_start pulse.
- H_POL=1, V_POL=1, 640x480 constants (800x525 totals) -> hsync high for hc 656..751, vsync high for vc 490..491.
- Force hc=2000 via bench deposit -> next enabled edge gives hc=0, and counting continues normally.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared types and constants for the VGA raster timing generator.
//   coord_t    : 11-bit unsigned raster coordinate (hc / vc)
//   window_t   : [first, stop) interval of a sync pulse on one axis
//   XGA_*      : 1024x768@60 timing (65 MHz pixel clock)
//   VGA_*      : 640x480@60 timing (25.175 MHz pixel clock)
//   syncWindow : turns visible/porch/sync widths into a sync interval
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int COORD_W   = 11;
  localparam int MAX_TOTAL = 2048;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t first;
    coord_t stop;
  } window_t;

  localparam int XGA_H_VISIBLE = 1024;
  localparam int XGA_H_FP      = 24;
  localparam int XGA_H_SYNC    = 136;
  localparam int XGA_H_BP      = 160;
  localparam int XGA_V_VISIBLE = 768;
  localparam int XGA_V_FP      = 3;
  localparam int XGA_V_SYNC    = 6;
  localparam int XGA_V_BP      = 29;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  // The sync pulse sits right after the front porch; stop is exclusive.
  function automatic window_t syncWindow(input int visible, input int porch, input int width);
    window_t w;
    w.first = coord_t'(visible + porch);
    w.stop  = coord_t'(visible + porch + width);
    return w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Raster bus between the timing generator and its consumers.
//   pix_en      : pixel-advance enable (consumer/system -> generator)
//   hc, vc      : raster counters
//   hsync/vsync : sync strobes, polarity set by the generator parameters
//   blank       : high outside the visible area
//   line_start  : one-clock pulse when hc becomes 0
//   frame_start : one-clock pulse when hc and vc both become 0
// master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic                  pix_en;
  vga_timing_pkg::coord_t hc;
  vga_timing_pkg::coord_t vc;
  logic                  hsync;
  logic                  vsync;
  logic                  blank;
  logic                  line_start;
  logic                  frame_start;

  modport master (
    input  pix_en,
    output hc, vc, hsync, vsync, blank, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hc, vc, hsync, vsync, blank, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: wrapping counter with enable, terminal count and a
// registered sync strobe decoded from the value being loaded.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   i_en    : advance enable
//   o_count : current counter value (register)
//   o_next  : value the counter loads on the next enabled edge
//   o_tc    : counter sits at TOTAL-1
//   o_sync  : sync strobe (register), aligned with o_count
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = XGA_H_VISIBLE,
  parameter int FP      = XGA_H_FP,
  parameter int SYNC    = XGA_H_SYNC,
  parameter int BP      = XGA_H_BP,
  parameter bit POL     = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  output coord_t o_count,
  output coord_t o_next,
  output logic   o_tc,
  output logic   o_sync
);

  localparam int      TOTAL    = VISIBLE + FP + SYNC + BP;
  localparam coord_t  LAST     = coord_t'(TOTAL - 1);
  localparam window_t SYNC_WIN = syncWindow(VISIBLE, FP, SYNC);

  if (TOTAL > MAX_TOTAL || FP == 0 || SYNC == 0 || BP == 0) begin : gBadParams
    $error("vga_axis_counter: total above 2048 or zero porch/sync width");
  end

  coord_t r_count;
  logic   r_sync;
  coord_t w_next;
  logic   w_inSync;

  // Next value and the sync decode of that value. Using >= LAST instead
  // of == LAST also recovers from an out-of-range count (e.g. an upset
  // bit) by sending it straight back to 0.
  always_comb begin
    w_next   = (r_count >= LAST) ? '0 : r_count + 11'd1;
    w_inSync = (w_next >= SYNC_WIN.first) && (w_next < SYNC_WIN.stop);
  end

  // Counter and sync strobe load together so the strobe always matches
  // the count it is reported with.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_sync  <= ~POL;
    end else if (i_en) begin
      r_count <= w_next;
      r_sync  <= w_inSync ? POL : ~POL;
    end
  end

  assign o_count = r_count;
  assign o_next  = w_next;
  assign o_tc    = (r_count == LAST);
  assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator: hc/vc counters, sync strobes, blank and the
// line/frame start markers used by the framebuffer fetch logic.
//   clk : system clock
//   rst : synchronous active-low reset, wins over pix_en
//   bus : vga_timing_gen_if master (pix_en in; hc, vc, hsync, vsync,
//         blank, line_start, frame_start out, all registered)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = XGA_H_VISIBLE,
  parameter int H_FP      = XGA_H_FP,
  parameter int H_SYNC    = XGA_H_SYNC,
  parameter int H_BP      = XGA_H_BP,
  parameter int V_VISIBLE = XGA_V_VISIBLE,
  parameter int V_FP      = XGA_V_FP,
  parameter int V_SYNC    = XGA_V_SYNC,
  parameter int V_BP      = XGA_V_BP,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t V_LAST_C = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  coord_t w_hCount, w_hNext, w_vCount, w_vNext, w_vFuture;
  logic   w_hTc, w_vTc, w_vEn, w_vWraps, w_hSync, w_vSync;
  logic   r_blank, r_lineStart, r_frameStart;

  // The vertical axis only steps when the horizontal axis is at the end
  // of a line, so vsync edges land on the same edge as hc wrapping.
  assign w_vEn = bus.pix_en & w_hTc;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
  ) u_hAxis (
    .clk(clk), .rst(rst), .i_en(bus.pix_en),
    .o_count(w_hCount), .o_next(w_hNext), .o_tc(w_hTc), .o_sync(w_hSync)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
  ) u_vAxis (
    .clk(clk), .rst(rst), .i_en(w_vEn),
    .o_count(w_vCount), .o_next(w_vNext), .o_tc(w_vTc), .o_sync(w_vSync)
  );

  // Where vc will be after the next enabled edge, and whether that edge
  // takes vc to 0 (normal last line, or recovery from an out-of-range vc).
  always_comb begin
    w_vFuture = w_hTc ? w_vNext : w_vCount;
    w_vWraps  = w_vTc | (w_vCount > V_LAST_C);
  end

  // Blank and the start markers are decoded from the values being loaded
  // so they line up with hc/vc; the markers drop whenever pix_en is low
  // so each one lasts exactly one clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blank      <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else if (bus.pix_en) begin
      r_blank      <= (w_hNext >= H_VIS_C) | (w_vFuture >= V_VIS_C);
      r_lineStart  <= (w_hNext == '0);
      r_frameStart <= w_hTc & w_vWraps;
    end else begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end
  end

  assign bus.hc          = w_hCount;
  assign bus.vc          = w_vCount;
  assign bus.hsync       = w_hSync;
  assign bus.vsync       = w_vSync;
  assign bus.blank       = r_blank;
  assign bus.line_start  = r_lineStart;
  assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators: 0 = 1024x768 defaults, 1 = tiny 25x12 raster with
// active-high syncs (full frames fit in a short run), 2 = 640x480 with
// active-high syncs. A position-based raster model predicts every output
// of every generator each cycle; directed checks pin the model.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HV[3] = '{XGA_H_VISIBLE, 16, VGA_H_VISIBLE};
  localparam int HF[3] = '{XGA_H_FP,      2,  VGA_H_FP};
  localparam int HS[3] = '{XGA_H_SYNC,    3,  VGA_H_SYNC};
  localparam int HB[3] = '{XGA_H_BP,      4,  VGA_H_BP};
  localparam int VV[3] = '{XGA_V_VISIBLE, 6,  VGA_V_VISIBLE};
  localparam int VF[3] = '{XGA_V_FP,      1,  VGA_V_FP};
  localparam int VS[3] = '{XGA_V_SYNC,    2,  VGA_V_SYNC};
  localparam int VB[3] = '{XGA_V_BP,      3,  VGA_V_BP};
  localparam bit HP[3] = '{1'b0, 1'b1, 1'b1};
  localparam bit VP[3] = '{1'b0, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rstN[3];
  logic        en[3];
  logic [31:0] act[3];
  int          pos[3];
  bit          mLs[3];
  bit          mFs[3];
  bit          live[3];
  int          total = 0;
  int          bad = 0;

  int hsLow, lsCnt, fsCnt, blankCnt, vsCnt, hsCnt, fs1Cnt, hs2Cnt, hs2First, hsFirst, vExp, found;

  vga_timing_gen_if if0();
  vga_timing_gen_if if1();
  vga_timing_gen_if if2();

  vga_timing_gen dut0 (.clk(clk), .rst(rstN[0]), .bus(if0));

  vga_timing_gen #(
    .H_VISIBLE(HV[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_VISIBLE(VV[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut1 (.clk(clk), .rst(rstN[1]), .bus(if1));

  vga_timing_gen #(
    .H_VISIBLE(VGA_H_VISIBLE), .H_FP(VGA_H_FP), .H_SYNC(VGA_H_SYNC), .H_BP(VGA_H_BP),
    .V_VISIBLE(VGA_V_VISIBLE), .V_FP(VGA_V_FP), .V_SYNC(VGA_V_SYNC), .V_BP(VGA_V_BP),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut2 (.clk(clk), .rst(rstN[2]), .bus(if2));

  always #5 clk = ~clk;

  assign en[0] = if0.pix_en;
  assign en[1] = if1.pix_en;
  assign en[2] = if2.pix_en;
  assign act[0] = {5'b0, if0.hc, if0.vc, if0.hsync, if0.vsync, if0.blank, if0.line_start, if0.frame_start};
  assign act[1] = {5'b0, if1.hc, if1.vc, if1.hsync, if1.vsync, if1.blank, if1.line_start, if1.frame_start};
  assign act[2] = {5'b0, if2.hc, if2.vc, if2.hsync, if2.vsync, if2.blank, if2.line_start, if2.frame_start};

  // Expected outputs from a linear raster position: pos counts enabled
  // pixels since reset, modulo the frame size.
  function automatic logic [31:0] modelVec(input int k, input int p, input bit ls, input bit fs);
    int hTot = HV[k] + HF[k] + HS[k] + HB[k];
    int h    = p % hTot;
    int v    = p / hTot;
    bit hOn  = (h >= HV[k] + HF[k]) && (h < HV[k] + HF[k] + HS[k]);
    bit vOn  = (v >= VV[k] + VF[k]) && (v < VV[k] + VF[k] + VS[k]);
    bit hs   = hOn ? HP[k] : ~HP[k];
    bit vs   = vOn ? VP[k] : ~VP[k];
    bit bl   = (h >= HV[k]) || (v >= VV[k]);
    return {5'b0, 11'(h), 11'(v), hs, vs, bl, ls, fs};
  endfunction

  function automatic int frameLen(input int k);
    return (HV[k] + HF[k] + HS[k] + HB[k]) * (VV[k] + VF[k] + VS[k] + VB[k]);
  endfunction

  function automatic int lineLen(input int k);
    return HV[k] + HF[k] + HS[k] + HB[k];
  endfunction

  // Model advance: one pixel per enabled edge, markers when the new
  // position starts a line / a frame.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstN[k]) begin
        pos[k] <= 0;
        mLs[k] <= 1'b0;
        mFs[k] <= 1'b0;
      end else if (en[k]) begin
        pos[k] <= (pos[k] + 1) % frameLen(k);
        mLs[k] <= ((pos[k] + 1) % lineLen(k)) == 0;
        mFs[k] <= ((pos[k] + 1) % frameLen(k)) == 0;
      end else begin
        mLs[k] <= 1'b0;
        mFs[k] <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Per-cycle comparison of every live generator against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (live[k]) checkOutput($sformatf("model%0d", k), act[k], modelVec(k, pos[k], mLs[k], mFs[k]));
    end
  end

  task automatic applyStimulus(input bit r0, input bit r1, input bit e0, input bit e1, input int cycles);
    rstN[0] = r0;
    rstN[1] = r1;
    if0.pix_en = e0;
    if1.pix_en = e1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    live[0] = 1'b1; live[1] = 1'b1; live[2] = 1'b1;
    rstN[2] = 1'b0;
    if2.pix_en = 1'b1;

    // Reset held with pix_en high: reset must win.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2);
    checkOutput("rst_hc0", 32'(if0.hc), 32'd0);
    checkOutput("rst_vc0", 32'(if0.vc), 32'd0);
    checkOutput("rst_hsync0", 32'(if0.hsync), 32'd1);
    checkOutput("rst_vsync0", 32'(if0.vsync), 32'd1);
    checkOutput("rst_blank0", 32'(if0.blank), 32'd0);
    checkOutput("rst_ls0", 32'(if0.line_start), 32'd0);
    checkOutput("rst_hsync1", 32'(if1.hsync), 32'd0);
    checkOutput("rst_hsync2", 32'(if2.hsync), 32'd0);

    rstN[2] = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
    checkOutput("first_hc0", 32'(if0.hc), 32'd1);
    checkOutput("first_ls0", 32'(if0.line_start), 32'd0);

    // One full XGA line sampled from hc=1 through the wrap to hc=0.
    hsLow = 0; lsCnt = 0; blankCnt = 0; fs1Cnt = 0; hs2Cnt = 0; hs2First = -1; hsFirst = -1;
    for (int i = 0; i < 1344; i++) begin
      if (i > 0) @(negedge clk);
      if (!if0.hsync) begin
        hsLow++;
        if (hsFirst < 0) hsFirst = int'(if0.hc);
      end
      if (if0.line_start) lsCnt++;
      if (if0.blank) blankCnt++;
      if (if1.frame_start) fs1Cnt++;
      if (if2.hsync) begin
        hs2Cnt++;
        if (hs2First < 0) hs2First = int'(if2.hc);
      end
    end
    checkOutput("line_hsync_low", 32'(hsLow), 32'd136);
    checkOutput("line_hsync_first", 32'(hsFirst), 32'd1048);
    checkOutput("line_ls_count", 32'(lsCnt), 32'd1);
    checkOutput("line_blank_count", 32'(blankCnt), 32'd320);
    checkOutput("wrap_hc0", 32'(if0.hc), 32'd0);
    checkOutput("wrap_vc0", 32'(if0.vc), 32'd1);
    checkOutput("wrap_ls0", 32'(if0.line_start), 32'd1);
    checkOutput("wrap_fs0", 32'(if0.frame_start), 32'd0);
    checkOutput("tiny_fs_count", 32'(fs1Cnt), 32'd4);
    checkOutput("vga_hsync_high", 32'(hs2Cnt), 32'd96);
    checkOutput("vga_hsync_first", 32'(hs2First), 32'd656);

    // Mid-frame reset at hc=500, vc=1.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 500);
    checkOutput("mid_hc0", 32'(if0.hc), 32'd500);
    checkOutput("mid_vc0", 32'(if0.vc), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1);
    checkOutput("midrst_hc0", 32'(if0.hc), 32'd0);
    checkOutput("midrst_vc0", 32'(if0.vc), 32'd0);
    checkOutput("midrst_sync0", 32'({if0.hsync, if0.vsync}), 32'd3);
    checkOutput("midrst_blank0", 32'(if0.blank), 32'd0);
    checkOutput("midrst_fs0", 32'(if0.frame_start), 32'd0);
    checkOutput("midrst_ls0", 32'(if0.line_start), 32'd0);

    // Release with pix_en low: nothing moves until it rises.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3);
    checkOutput("hold_hc0", 32'(if0.hc), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
    checkOutput("resume_hc0", 32'(if0.hc), 32'd1);

    // Tiny raster: one complete 300-pixel frame after reset.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
    lsCnt = 0; fsCnt = 0; blankCnt = 0; vsCnt = 0; hsCnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clk);
      if (if1.line_start) lsCnt++;
      if (if1.frame_start) fsCnt++;
      if (if1.blank) blankCnt++;
      if (if1.vsync) vsCnt++;
      if (if1.hsync) hsCnt++;
    end
    checkOutput("frame_fs_count", 32'(fsCnt), 32'd1);
    checkOutput("frame_ls_count", 32'(lsCnt), 32'd12);
    checkOutput("frame_blank_count", 32'(blankCnt), 32'd204);
    checkOutput("frame_vsync_high", 32'(vsCnt), 32'd50);
    checkOutput("frame_hsync_high", 32'(hsCnt), 32'd36);
    checkOutput("frame_end_pos", 32'({if1.hc, if1.vc, if1.frame_start}), 32'd1);

    // Alternating pix_en: 600 clocks are 300 enabled pixels = one frame.
    lsCnt = 0; fsCnt = 0;
    for (int i = 0; i < 600; i++) begin
      if1.pix_en = (i % 2 == 0);
      @(negedge clk);
      if (if1.line_start) lsCnt++;
      if (if1.frame_start) fsCnt++;
    end
    if1.pix_en = 1'b1;
    checkOutput("alt_ls_cycles", 32'(lsCnt), 32'd12);
    checkOutput("alt_fs_cycles", 32'(fsCnt), 32'd1);
    checkOutput("alt_end_hc", 32'(if1.hc), 32'd0);
    checkOutput("alt_end_vc", 32'(if1.vc), 32'd0);

    // Out-of-range hc recovery on generator 0.
    live[0] = 1'b0;
    @(negedge clk);
    vExp = pos[0] / lineLen(0);
    force dut0.u_hAxis.r_count = 11'd2000;
    @(negedge clk);
    checkOutput("guard_ls0", 32'(if0.line_start), 32'd1);
    checkOutput("guard_vc0", 32'(if0.vc), 32'(vExp));
    release dut0.u_hAxis.r_count;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (if0.line_start) begin
        found = 1;
        break;
      end
    end
    checkOutput("guard_resync", 32'(found), 32'd1);
    checkOutput("guard_hc0", 32'(if0.hc), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5);
    checkOutput("guard_count_hc0", 32'(if0.hc), 32'd5);
    checkOutput("guard_count_ls0", 32'(if0.line_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
